keypad_cmd_encoder: RTL and testbench

Producer end of the input-command interface. Scans a 4x5 active-low key matrix, debounces it, and encodes one keypress into an `IC_* command word. The word is held on in_cmd with a valid/ack handshake until the controller consumes it. Sits between board pins and the controller's in_cmd input; exactly one command is issued per physical press.

---
 rtl/keypad_cmd_encoder_pkg.sv | 38 +++
 rtl/keypad_keymap_rom.sv | 56 +++++
 rtl/keypad_cmd_encoder.sv | 152 +++++++++++++++
 tb/tb_keypad_cmd_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_cmd_encoder_pkg.sv
// Shared input-command codes and keypad helpers.
// Imported by the keypad encoder and its keymap ROM.
package keypad_cmd_encoder_pkg;

  localparam int IC_N = 5;

  localparam logic [IC_N-1:0] IC_NONE = 5'd0;
  localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;
  localparam logic [IC_N-1:0] IC_NUM1 = 5'd2;
  localparam logic [IC_N-1:0] IC_NUM2 = 5'd3;
  localparam logic [IC_N-1:0] IC_NUM3 = 5'd4;
  localparam logic [IC_N-1:0] IC_NUM4 = 5'd5;
  localparam logic [IC_N-1:0] IC_NUM5 = 5'd6;
  localparam logic [IC_N-1:0] IC_NUM6 = 5'd7;
  localparam logic [IC_N-1:0] IC_NUM7 = 5'd8;
  localparam logic [IC_N-1:0] IC_NUM8 = 5'd9;
  localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
  localparam logic [IC_N-1:0] IC_DOT  = 5'd11;
  localparam logic [IC_N-1:0] IC_ADD  = 5'd12;
  localparam logic [IC_N-1:0] IC_SUB  = 5'd13;
  localparam logic [IC_N-1:0] IC_MUL  = 5'd14;
  localparam logic [IC_N-1:0] IC_DIV  = 5'd15;
  localparam logic [IC_N-1:0] IC_EQU  = 5'd16;
  localparam logic [IC_N-1:0] IC_CLR  = 5'd17;
  localparam logic [IC_N-1:0] IC_LBK  = 5'd18;
  localparam logic [IC_N-1:0] IC_RBK  = 5'd19;

  localparam logic [2:0] COL_NONE = 3'd5;

  // Index of the lowest active-low column, COL_NONE if all high.
  function automatic logic [2:0] lowest_low(input logic [4:0] col);
    lowest_low = COL_NONE;
    for (int i = 4; i >= 0; i--) begin
      if (!col[i]) lowest_low = 3'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_keymap_rom.sv
// Keypad layout ROM: (row,col) -> input-command code.
// Swap this module to support a different key legend.
module keypad_keymap_rom
  import keypad_cmd_encoder_pkg::*;
(
  input  logic [1:0]      row,
  input  logic [2:0]      col,
  output logic [IC_N-1:0] code
);

  always_comb begin
    code = IC_NONE;
    case (row)
      2'd0: begin
        case (col)
          3'd0:    code = IC_NUM7;
          3'd1:    code = IC_NUM8;
          3'd2:    code = IC_NUM9;
          3'd3:    code = IC_DIV;
          3'd4:    code = IC_CLR;
          default: code = IC_NONE;
        endcase
      end
      2'd1: begin
        case (col)
          3'd0:    code = IC_NUM4;
          3'd1:    code = IC_NUM5;
          3'd2:    code = IC_NUM6;
          3'd3:    code = IC_MUL;
          3'd4:    code = IC_LBK;
          default: code = IC_NONE;
        endcase
      end
      2'd2: begin
        case (col)
          3'd0:    code = IC_NUM1;
          3'd1:    code = IC_NUM2;
          3'd2:    code = IC_NUM3;
          3'd3:    code = IC_SUB;
          3'd4:    code = IC_RBK;
          default: code = IC_NONE;
        endcase
      end
      default: begin
        case (col)
          3'd0:    code = IC_NUM0;
          3'd1:    code = IC_DOT;
          3'd2:    code = IC_EQU;
          3'd3:    code = IC_ADD;
          default: code = IC_NONE;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/keypad_cmd_encoder.sv
// 4x5 keypad scanner/debouncer issuing one command per press
// over a valid/ack handshake.
module keypad_cmd_encoder
  import keypad_cmd_encoder_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [3:0]      kp_row,
  input  logic [4:0]      kp_col,
  output logic [IC_N-1:0] in_cmd,
  output logic            cmd_valid,
  input  logic            cmd_ack
);

  typedef enum logic [1:0] {
    KE_SCAN,
    KE_DEBOUNCE,
    KE_HOLD,
    KE_RELEASE
  } ke_state_e;

  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SETTLE    = SW'(2);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  ke_state_e       state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [SW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [IC_N-1:0] cmd_q, cmd_d;
  logic            vld_q, vld_d;
  logic [4:0]      sync1_q, sync1_d;
  logic [4:0]      sync2_q, sync2_d;

  logic [4:0]      col_s;
  logic [2:0]      low;
  logic [IC_N-1:0] key_code;
  logic [SW-1:0]   tmr_inc;
  logic [DW-1:0]   cnt_inc;

  keypad_keymap_rom u_rom (
    .row  (row_q),
    .col  (col_q),
    .code (key_code)
  );

  assign col_s = sync2_q;
  assign low   = lowest_low(col_s);

  // Saturating increments: counters hold at all-ones.
  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + SW'(1);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + DW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    vld_d   = vld_q;
    sync1_d = kp_col;
    sync2_d = sync1_q;
    unique case (state_q)
      KE_SCAN: begin
        if (tmr_q >= SETTLE && low != COL_NONE) begin
          col_d   = low;
          cnt_d   = '0;
          state_d = KE_DEBOUNCE;
        end else if (tmr_q >= SCAN_LAST) begin
          row_d = row_q + 2'd1;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      KE_DEBOUNCE: begin
        if (low != col_q) begin
          state_d = KE_SCAN;
          tmr_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          cnt_d = '0;
          if (key_code == IC_NONE) begin
            state_d = KE_RELEASE;
          end else begin
            cmd_d   = key_code;
            vld_d   = 1'b1;
            state_d = KE_HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      KE_HOLD: begin
        if (cmd_ack) begin
          cmd_d   = IC_NONE;
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = KE_RELEASE;
        end
      end
      KE_RELEASE: begin
        if (col_s != 5'b11111) begin
          cnt_d = '0;
        end else if (cnt_q >= DEB_LAST) begin
          cnt_d   = '0;
          tmr_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = KE_SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = KE_SCAN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= KE_SCAN;
      row_q   <= '0;
      col_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= IC_NONE;
      vld_q   <= 1'b0;
      sync1_q <= 5'b11111;
      sync2_q <= 5'b11111;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign kp_row    = ~(4'b0001 << row_q);
  assign in_cmd    = cmd_q;
  assign cmd_valid = vld_q;

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed bench for keypad_cmd_encoder with a modelled key matrix.
// Runs with SCAN_DIV=4, DEB_CYCLES=8.
module tb_keypad_cmd_encoder;
  import keypad_cmd_encoder_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [3:0]      kp_row;
  logic [4:0]      kp_col;
  logic [IC_N-1:0] in_cmd;
  logic            cmd_valid;
  logic            cmd_ack;
  logic [3:0][4:0] keys;

  int total = 0;
  int bad   = 0;

  keypad_cmd_encoder #(
    .SCAN_DIV   (4),
    .DEB_CYCLES (8)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .kp_row    (kp_row),
    .kp_col    (kp_col),
    .in_cmd    (in_cmd),
    .cmd_valid (cmd_valid),
    .cmd_ack   (cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    kp_col = 5'b11111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r][c] && !kp_row[r]) kp_col[c] = 1'b0;
  end

  typedef struct {
    int              r;
    int              c;
    logic [IC_N-1:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, cmd_valid}, 32'd1);
  endtask

  task automatic wait_row1_start();
    logic [3:0] prev;
    int found;
    found = 0;
    prev = kp_row;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (kp_row == 4'b1101 && prev != 4'b1101) begin
        found = 1;
        break;
      end
      prev = kp_row;
    end
    chk("row1_start", found, 1);
  endtask

  task automatic ack_release(input string nm);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk({nm, "_vld_drop"}, {31'd0, cmd_valid}, 32'd0);
    chk({nm, "_cmd_none"}, {27'd0, in_cmd}, {27'd0, IC_NONE});
    keys = '0;
    repeat (20) tick();
  endtask

  initial begin
    int errs;
    tbl[0] = '{0, 4, IC_CLR};
    tbl[1] = '{1, 3, IC_MUL};
    tbl[2] = '{2, 1, IC_NUM2};
    tbl[3] = '{3, 2, IC_EQU};
    tbl[4] = '{3, 1, IC_DOT};
    tbl[5] = '{2, 4, IC_RBK};
    tbl[6] = '{0, 0, IC_NUM7};

    rst_n   = 1'b0;
    cmd_ack = 1'b0;
    keys    = '0;

    // Reset and idle row scan
    repeat (3) tick();
    chk("rst_row", kp_row, 4'b1110);
    chk("rst_vld", cmd_valid, 0);
    chk("rst_cmd", in_cmd, IC_NONE);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] er;
      tick();
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_row", kp_row, er);
      chk("scan_vld", cmd_valid, 0);
    end

    // Press-to-valid latency on row 1
    wait_row1_start();
    keys[1][1] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 10) chk("lat_early", cmd_valid, 0);
      if (n == 11) begin
        chk("lat_vld", cmd_valid, 1);
        chk("lat_cmd", in_cmd, IC_NUM5);
      end
    end
    repeat (5) tick();
    chk("hold_vld", cmd_valid, 1);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("ack_vld", cmd_valid, 0);
    chk("ack_cmd", in_cmd, IC_NONE);
    repeat (3) tick();
    chk("no_repeat", cmd_valid, 0);
    keys = '0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 9) chk("rel_frozen", kp_row, 4'b1101);
      if (n == 10) chk("rel_next", kp_row, 4'b1011);
    end

    // Table of single clean presses
    foreach (tbl[i]) begin
      keys = '0;
      keys[tbl[i].r][tbl[i].c] = 1'b1;
      wait_valid("tbl_wait");
      chk("tbl_cmd", in_cmd, tbl[i].exp);
      repeat (2) tick();
      chk("tbl_stable", in_cmd, tbl[i].exp);
      ack_release("tbl");
    end

    // Bouncy press on (3,0)
    errs = 0;
    keys[3][0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cmd_valid) errs++;
      if (n % 3 == 0) keys[3][0] = ~keys[3][0];
    end
    chk("bounce_quiet", errs, 0);
    keys[3][0] = 1'b1;
    wait_valid("bounce_wait");
    chk("bounce_cmd", in_cmd, IC_NUM0);
    ack_release("bounce");

    // Long hold without ack
    keys[0][3] = 1'b1;
    wait_valid("div_wait");
    chk("div_cmd", in_cmd, IC_DIV);
    errs = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!cmd_valid || in_cmd != IC_DIV) errs++;
    end
    chk("div_held", errs, 0);
    ack_release("div");
    errs = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (cmd_valid) errs++;
    end
    chk("div_no_repeat", errs, 0);

    // Two keys on one row: lowest column wins
    keys[2][0] = 1'b1;
    keys[2][2] = 1'b1;
    wait_valid("two_wait");
    chk("two_cmd", in_cmd, IC_NUM1);
    ack_release("two");

    // Reset during debounce drops the press
    wait_row1_start();
    keys[1][2] = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    keys  = '0;
    tick();
    chk("mid_rst_row", kp_row, 4'b1110);
    chk("mid_rst_vld", cmd_valid, 0);
    chk("mid_rst_cmd", in_cmd, IC_NONE);
    rst_n = 1'b1;
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cmd_valid) errs++;
    end
    chk("mid_rst_quiet", errs, 0);

    // Unmapped key (3,4): no command, scan resumes after release
    keys[3][4] = 1'b1;
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cmd_valid) errs++;
    end
    chk("none_quiet", errs, 0);
    chk("none_frozen", kp_row, 4'b0111);
    keys = '0;
    errs = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (kp_row == 4'b1110) begin
        errs = 1;
        break;
      end
    end
    chk("none_resume", errs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
